can_wb_byte_bridge: RTL and testbench
=====================================

// Module: can_wb_byte_bridge
// PURPOSE
//  Sequencer between the 32-bit Caravel Wishbone slave port and the 8-bit Wishbone port of the CAN controller core.
//  Decodes an address window and splits each 32-bit access into ordered 8-bit CAN register accesses, one per
//  selected byte lane. Gathers read bytes into a 32-bit word and returns a single host ack.
//  Bounds every CAN access with a timeout so a hung core cannot stall the management bus.
// PARAMETERS
//  BASE_ADDR  32'h3000_0000  window base; a request matches when (wbs_adr_i & ADDR_MASK) == BASE_ADDR
//  ADDR_MASK  32'hFFFF_FF00  window mask (256-byte window = CAN register space)
//  TIMEOUT    255            max ISSUE cycles per byte access before abort (>=1; counter width = $clog2(TIMEOUT+1))
// PORTS
//  wb_clk_i    in   1   single clock for the block
//  wb_rst_ni   in   1   asynchronous active-low reset
//  wbs_cyc_i   in   1   host cycle
//  wbs_stb_i   in   1   host strobe
//  wbs_we_i    in   1   host write enable
//  wbs_sel_i   in   4   host byte-lane select
//  wbs_adr_i   in   32  host byte address
//  wbs_dat_i   in   32  host write data
//  wbs_ack_o   out  1   host ack, 1-cycle pulse
//  wbs_dat_o   out  32  host read data, valid with wbs_ack_o
//  can_cyc_o   out  1   CAN core cycle
//  can_stb_o   out  1   CAN core strobe (equal to can_cyc_o)
//  can_we_o    out  1   CAN core write enable
//  can_adr_o   out  8   CAN register address = {adr[7:2], lane[1:0]}
//  can_dat_o   out  8   CAN write byte = wbs_dat_i[8*lane +: 8]
//  can_dat_i   in   8   CAN read byte
//  can_ack_i   in   1   CAN core ack
//  busy_o      out  1   high in any state other than IDLE
//  timeout_o   out  1   1-cycle pulse when a byte access is aborted
// BEHAVIOUR
//  Reset: every output 0; FSM in IDLE; captured request and read buffer cleared. Applies immediately, including mid-access.
//  FSM states: IDLE, ISSUE, GAP, DONE.
//  IDLE
//   - Accepts when cyc&stb&window match&!wbs_ack_o.
//   - Registers we, adr[7:2], sel, dat; clears rdbuf.
//   - Goes to ISSUE at the lowest set sel bit, or to DONE if sel==0.
//  ISSUE
//   - can_cyc_o=can_stb_o=1; adr, data and we held stable; timeout counter increments each cycle.
//   - On can_ack_i: latch can_dat_i into rdbuf lane (reads only); clear lane from pending mask.
//   - On counter==TIMEOUT with no ack: drop strobe; rdbuf lane=8'hFF (reads); timeout_o=1 for that cycle; clear lane from pending.
//   - Next state: GAP if lanes remain, else DONE.
//  GAP
//   - Exactly 1 cycle with strobe low; then ISSUE on the next ascending pending lane.
//  DONE
//   - wbs_ack_o=1 for one cycle; wbs_dat_o=rdbuf (unselected lanes 0; writes return 0); then IDLE.
//   - wbs_dat_o returns to 0 when ack is low.
//  Latency: CAN ack in the first ISSUE cycle gives host ack 2 cycles after accept for 1 lane, 2n cycles for n lanes.
//  Host drops cyc during ISSUE/GAP:
//   - The byte access already on the CAN bus completes (ack or timeout); strobe is never cut mid-access except by reset.
//   - Remaining lanes are discarded; no host ack; return to IDLE.
//  Requests outside the window: ignored, no ack, no CAN activity.
//  Requests arriving while busy: not sampled.
//  can_ack_i outside ISSUE: ignored.
// TESTING
//  Write sel=4'b0101, adr=BASE+0x10, dat=0xAABBCCDD, CAN acks 2 cycles after stb
//   -> CAN writes (0x10,0xDD), 1 GAP cycle, then (0x12,0xBB); one wbs_ack_o pulse.
//  Read sel=4'hF, adr=BASE+0x04, CAN returns 0x40|adr
//   -> CAN addresses 0x04..0x07 in order; wbs_dat_o=0x47464544.
//  sel=4'b0000 read at BASE
//   -> no can_stb_o; wbs_ack_o 1 cycle after accept; wbs_dat_o=0.
//  Access at BASE+0x100
//   -> no wbs_ack_o and no can_stb_o for 20 cycles; busy_o stays 0.
//  TIMEOUT=8, CAN never acks, read sel=4'b0010
//   -> stb high 8 cycles; timeout_o pulses once; wbs_dat_o=0x0000FF00; ack follows.
//  Host drops cyc in lane 0 of a 4-lane write
//   -> lane 0 completes; lanes 1-3 never issued; no ack.
//  Assert wb_rst_ni mid-ISSUE
//   -> can_stb_o, busy_o low immediately; next request served normally.

Source files
------------

// File: rtl/can_wb_byte_bridge.sv
// -----------------------------------------------------------------------------
// can_wb_byte_bridge
//   Sequences 32-bit host Wishbone accesses onto the 8-bit Wishbone port of a
//   CAN controller core. A host request that hits the address window is split
//   into one CAN byte access per selected lane, issued in ascending lane order
//   with one idle cycle between accesses. Read bytes are gathered into a 32-bit
//   word that is returned with a single host ack. Every byte access is bounded
//   by a cycle budget so a hung core cannot stall the management bus.
//
// Ports
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i         host request qualifiers
//   wbs_sel_i[3:0]               host byte-lane select
//   wbs_adr_i[31:0]              host byte address
//   wbs_dat_i[31:0]              host write data
//   wbs_ack_o, wbs_dat_o[31:0]   host ack pulse and read data (0 when no ack)
//   can_cyc_o/stb_o/we_o         CAN core request qualifiers
//   can_adr_o[7:0]               CAN register address {adr[7:2], lane}
//   can_dat_o[7:0]               CAN write byte
//   can_dat_i[7:0], can_ack_i    CAN read byte and ack
//   busy_o                       sequencer not idle
//   timeout_o                    pulse when a byte access is aborted
// -----------------------------------------------------------------------------
module can_wb_byte_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        can_cyc_o,
  output logic        can_stb_o,
  output logic        can_we_o,
  output logic [7:0]  can_adr_o,
  output logic [7:0]  can_dat_o,
  input  logic [7:0]  can_dat_i,
  input  logic        can_ack_i,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           we_q, we_d;
  logic [5:0]     adr_q, adr_d;
  logic [31:0]    dat_q, dat_d;
  logic [3:0]     pend_q, pend_d;
  logic [1:0]     lane_q, lane_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    rdbuf_q, rdbuf_d;
  logic           drop_q, drop_d;

  logic           in_issue;
  logic           in_done;
  logic           hit;
  logic           tmo;
  logic           drop_now;
  logic [3:0]     pend_left;

  // Lowest set bit of a lane mask; callers only use it on non-zero masks.
  function automatic logic [1:0] low_lane(input logic [3:0] m);
    low_lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) low_lane = 2'(i);
    end
  endfunction

  assign in_issue = (state_q == S_ISSUE);
  assign in_done  = (state_q == S_DONE);

  assign hit = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o &
               ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);

  // cnt_q holds the number of ISSUE cycles spent on the current byte,
  // counting the present one, so the strobe is high exactly TIMEOUT cycles.
  assign tmo       = in_issue & ~can_ack_i & (cnt_q == TMO_VAL);
  assign pend_left = pend_q & ~(4'b0001 << lane_q);
  // Once the host abandons the cycle we remember it, so a brief reassertion
  // of cyc cannot resurrect the discarded lanes.
  assign drop_now  = drop_q | ~wbs_cyc_i;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    pend_d  = pend_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    rdbuf_d = rdbuf_q;
    drop_d  = drop_q;

    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          we_d    = wbs_we_i;
          adr_d   = wbs_adr_i[7:2];
          dat_d   = wbs_dat_i;
          pend_d  = wbs_sel_i;
          lane_d  = low_lane(wbs_sel_i);
          cnt_d   = CW'(1);
          rdbuf_d = 32'h0;
          drop_d  = 1'b0;
          state_d = (wbs_sel_i == 4'b0000) ? S_DONE : S_ISSUE;
        end
      end

      S_ISSUE: begin
        drop_d = drop_now;
        if (can_ack_i || tmo) begin
          pend_d = pend_left;
          if (!we_q) begin
            rdbuf_d[{lane_q, 3'b000} +: 8] = can_ack_i ? can_dat_i : 8'hFF;
          end
          if (drop_now) begin
            pend_d  = 4'b0000;
            state_d = S_IDLE;
          end else if (pend_left != 4'b0000) begin
            state_d = S_GAP;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_GAP: begin
        if (drop_now) begin
          pend_d  = 4'b0000;
          state_d = S_IDLE;
        end else begin
          lane_d  = low_lane(pend_q);
          cnt_d   = CW'(1);
          state_d = S_ISSUE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      adr_q   <= 6'h0;
      dat_q   <= 32'h0;
      pend_q  <= 4'h0;
      lane_q  <= 2'd0;
      cnt_q   <= '0;
      rdbuf_q <= 32'h0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      pend_q  <= pend_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      rdbuf_q <= rdbuf_d;
      drop_q  <= drop_d;
    end
  end

  // Outputs decode straight from the state register so the asynchronous
  // reset forces them low without waiting for a clock edge.
  assign can_cyc_o = in_issue;
  assign can_stb_o = in_issue;
  assign can_we_o  = in_issue & we_q;
  assign can_adr_o = in_issue ? {adr_q, lane_q} : 8'h00;
  assign can_dat_o = in_issue ? dat_q[{lane_q, 3'b000} +: 8] : 8'h00;
  assign wbs_ack_o = in_done;
  assign wbs_dat_o = in_done ? rdbuf_q : 32'h0;
  assign busy_o    = (state_q != S_IDLE);
  assign timeout_o = tmo;

endmodule

// File: tb/tb_can_wb_byte_bridge.sv
module tb_can_wb_byte_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        can_cyc_o, can_stb_o, can_we_o;
  logic [7:0]  can_adr_o, can_dat_o;
  logic [7:0]  can_dat_i;
  logic        can_ack_i;
  logic        busy_o, timeout_o;

  can_wb_byte_bridge #(
    .BASE_ADDR(BASE),
    .ADDR_MASK(32'hFFFF_FF00),
    .TIMEOUT  (8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .can_cyc_o(can_cyc_o),
    .can_stb_o(can_stb_o),
    .can_we_o (can_we_o),
    .can_adr_o(can_adr_o),
    .can_dat_o(can_dat_o),
    .can_dat_i(can_dat_i),
    .can_ack_i(can_ack_i),
    .busy_o   (busy_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 0;   // CAN model acks after this many extra stb cycles

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- bus monitor (sampled on falling edge) ----------------
  int cyc_n = 0;
  int stb_cycles = 0, to_cnt = 0, ack_cnt = 0;
  logic stb_prev = 1'b0;
  int        rise_q[$];
  logic [7:0] acc_adr[$];
  logic [7:0] acc_dat[$];
  logic       acc_we[$];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    stb_prev <= can_stb_o;
    if (can_stb_o) stb_cycles <= stb_cycles + 1;
    if (can_stb_o && !stb_prev) rise_q.push_back(cyc_n);
    if (can_stb_o && can_ack_i) begin
      acc_adr.push_back(can_adr_o);
      acc_dat.push_back(can_dat_o);
      acc_we.push_back(can_we_o);
    end
    if (timeout_o) to_cnt <= to_cnt + 1;
    if (wbs_ack_o) ack_cnt <= ack_cnt + 1;
  end

  // ---------------- CAN core model ----------------
  // Read data is 0x40 | register address.
  initial begin
    int run;
    run = 0;
    can_ack_i = 1'b0;
    can_dat_i = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (can_stb_o) run++; else run = 0;
      if (can_stb_o && run == ack_delay + 1) begin
        can_ack_i = 1'b1;
        can_dat_i = 8'h40 | can_adr_o;
      end else begin
        can_ack_i = 1'b0;
        can_dat_i = 8'h00;
      end
    end
  end

  // ---------------- host transaction ----------------
  task automatic wb_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, input int bound,
                         output bit got, output logic [31:0] rd, output int lat);
    int n;
    n = 0; got = 0; rd = 32'h0; lat = -1;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
    while (!got && n < bound) begin
      @(negedge clk);
      n++;
      if (wbs_ack_o) begin
        got = 1; rd = wbs_dat_o; lat = n - 1;
      end
    end
    @(posedge clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    $display("xfer we=%0d sel=%b adr=%08h dat=%08h -> ack=%0d rdata=%08h latency=%0d",
             we, sel, adr, dat, got, rd, lat);
  endtask

  task automatic wait_stb(input int bound);
    int n;
    n = 0;
    while (!can_stb_o && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    logic [31:0] rd;
    int          lat;
    int          a0, r0, s0, k0, t0;

    rst_n = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_ack",  wbs_ack_o, 1'b0);
    check_eq("rst_dat",  wbs_dat_o, 32'h0);
    check_eq("rst_stb",  can_stb_o, 1'b0);
    check_eq("rst_busy", busy_o,    1'b0);
    check_eq("rst_to",   timeout_o, 1'b0);
    check_eq("rst_adr",  can_adr_o, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-lane write, CAN acks 2 cycles after stb
    ack_delay = 2;
    a0 = acc_adr.size(); r0 = rise_q.size(); k0 = ack_cnt;
    wb_xfer(1'b1, 4'b0101, BASE + 32'h10, 32'hAABB_CCDD, 40, got, rd, lat);
    check_eq("wr_ack",    got, 1'b1);
    check_eq("wr_rdata",  rd, 32'h0);
    check_eq("wr_nacc",   acc_adr.size() - a0, 2);
    if (acc_adr.size() - a0 == 2) begin
      check_eq("wr0_adr", acc_adr[a0],   8'h10);
      check_eq("wr0_dat", acc_dat[a0],   8'hDD);
      check_eq("wr0_we",  acc_we[a0],    1'b1);
      check_eq("wr1_adr", acc_adr[a0+1], 8'h12);
      check_eq("wr1_dat", acc_dat[a0+1], 8'hBB);
    end
    if (rise_q.size() - r0 == 2)
      check_eq("wr_gap", rise_q[r0+1] - rise_q[r0], 4);   // 3 ISSUE + 1 GAP
    else
      check_eq("wr_nrise", rise_q.size() - r0, 2);
    check_eq("wr_nack",   ack_cnt - k0, 1);

    // Four-lane read, immediate CAN ack
    ack_delay = 0;
    a0 = acc_adr.size();
    wb_xfer(1'b0, 4'hF, BASE + 32'h04, 32'h0, 40, got, rd, lat);
    check_eq("rd4_ack",   got, 1'b1);
    check_eq("rd4_data",  rd, 32'h4746_4544);
    check_eq("rd4_lat",   lat, 8);
    check_eq("rd4_nacc",  acc_adr.size() - a0, 4);
    if (acc_adr.size() - a0 == 4)
      for (int i = 0; i < 4; i++)
        check_eq($sformatf("rd4_adr%0d", i), acc_adr[a0+i], 8'h04 + 8'(i));

    // Single-lane read latency
    wb_xfer(1'b0, 4'b1000, BASE + 32'h08, 32'h0, 40, got, rd, lat);
    check_eq("rd1_data",  rd, 32'h4B00_0000);
    check_eq("rd1_lat",   lat, 2);

    // Empty select
    s0 = stb_cycles;
    wb_xfer(1'b0, 4'b0000, BASE, 32'h0, 40, got, rd, lat);
    check_eq("sel0_ack",  got, 1'b1);
    check_eq("sel0_lat",  lat, 1);
    check_eq("sel0_data", rd, 32'h0);
    check_eq("sel0_stb",  stb_cycles - s0, 0);

    // Outside the window
    s0 = stb_cycles; k0 = ack_cnt;
    wb_xfer(1'b0, 4'hF, BASE + 32'h100, 32'h0, 20, got, rd, lat);
    check_eq("oow_ack",   got, 1'b0);
    check_eq("oow_stb",   stb_cycles - s0, 0);
    check_eq("oow_nack",  ack_cnt - k0, 0);
    check_eq("oow_busy",  busy_o, 1'b0);

    // CAN never acks: timeout on lane 1
    ack_delay = 255;
    s0 = stb_cycles; t0 = to_cnt;
    wb_xfer(1'b0, 4'b0010, BASE, 32'h0, 40, got, rd, lat);
    check_eq("tmo_ack",   got, 1'b1);
    check_eq("tmo_data",  rd, 32'h0000_FF00);
    check_eq("tmo_stb",   stb_cycles - s0, 8);
    check_eq("tmo_pulse", to_cnt - t0, 1);

    // Host drops cyc during lane 0 of a 4-lane write
    ack_delay = 3;
    a0 = acc_adr.size(); r0 = rise_q.size(); s0 = stb_cycles; k0 = ack_cnt;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'hF; wbs_adr_i = BASE + 32'h30; wbs_dat_i = 32'h1122_3344;
    wait_stb(10);
    check_eq("drop_stb_seen", can_stb_o, 1'b1);
    @(posedge clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    repeat (20) @(negedge clk);
    $display("xfer dropped we=1 sel=1111 adr=%08h", BASE + 32'h30);
    check_eq("drop_nacc",  acc_adr.size() - a0, 1);
    if (acc_adr.size() - a0 >= 1) begin
      check_eq("drop_adr", acc_adr[a0], 8'h30);
      check_eq("drop_dat", acc_dat[a0], 8'h44);
    end
    check_eq("drop_rises", rise_q.size() - r0, 1);
    check_eq("drop_stbcy", stb_cycles - s0, 4);
    check_eq("drop_nack",  ack_cnt - k0, 0);
    check_eq("drop_busy",  busy_o, 1'b0);

    // Reset in the middle of an ISSUE
    ack_delay = 255;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'b0001; wbs_adr_i = BASE + 32'h20;
    wait_stb(10);
    check_eq("mrst_stb_seen", can_stb_o, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_stb",  can_stb_o, 1'b0);
    check_eq("mrst_busy", busy_o,    1'b0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_sel_i = 4'h0; wbs_adr_i = 32'h0;
    $display("xfer reset mid-issue adr=%08h", BASE + 32'h20);
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    repeat (2) @(negedge clk);
    wb_xfer(1'b0, 4'b0001, BASE + 32'h20, 32'h0, 40, got, rd, lat);
    check_eq("post_ack",  got, 1'b1);
    check_eq("post_data", rd, 32'h0000_0060);
    check_eq("post_lat",  lat, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
